// File: rtl/mul16u_share_pkg.sv
`default_nettype none
// ============================================================================
// Package : mul16u_share_pkg
// Purpose : Shared constants and types for the shared 16x16 multiplier
//           arbiter and its combinational product-select core.
// Contents: MUL_W, PROD_W, APX_SHIFT, ID_W_MAX, issue_t {id, a, b, apx}
// Revision: 1.0 - initial release
// ============================================================================
package mul16u_share_pkg;

  localparam int MUL_W     = 16;
  localparam int PROD_W    = 32;
  localparam int APX_SHIFT = 24;
  // Widest requester tag (NREQ is at most 8).
  localparam int ID_W_MAX  = 3;

  typedef struct packed {
    logic [ID_W_MAX-1:0] id;
    logic [MUL_W-1:0]    a;
    logic [MUL_W-1:0]    b;
    logic                apx;
  } issue_t;

endpackage : mul16u_share_pkg
`default_nettype wire

// File: rtl/mul16u_core_sel.sv
`default_nettype none
// ============================================================================
// Module  : mul16u_core_sel
// Purpose : Combinational 16x16 unsigned product with exact/approximate
//           selection. The approximate result keeps only the product of the
//           top nibbles, placed at bits [31:24]; bits [23:0] are zero.
// Ports   : a, b  (in,  16) operands
//           apx   (in,   1) 1 = approximate, 0 = exact
//           prod  (out, 32) selected product
// Revision: 1.0 - initial release
// ============================================================================
module mul16u_core_sel
  import mul16u_share_pkg::*;
(
  input  logic [MUL_W-1:0]  a,
  input  logic [MUL_W-1:0]  b,
  input  logic              apx,
  output logic [PROD_W-1:0] prod
);

  localparam int NIB_W = 4;

  logic [PROD_W-1:0]    p_exact;
  logic [2*NIB_W-1:0]   p_hi;

  assign p_exact = PROD_W'(a) * PROD_W'(b);
  // Operands widened first so the nibble product keeps all 8 bits.
  assign p_hi    = (2*NIB_W)'(a[MUL_W-1 -: NIB_W]) * (2*NIB_W)'(b[MUL_W-1 -: NIB_W]);
  assign prod    = apx ? {p_hi, {APX_SHIFT{1'b0}}} : p_exact;

endmodule : mul16u_core_sel
`default_nettype wire

// File: rtl/mul16u_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mul16u_share_arbiter
// Purpose : Round-robin sharing of one pipelined 16x16 unsigned multiplier
//           among NREQ requesters. Results leave in issue order, tagged with
//           the requester id and the mode (exact/approximate) used.
// Ports   : clk, rst_n            clock / async active-low reset
//           req_valid/req_ready   per-requester handshake (ready one-hot)
//           req_a, req_b          16-bit operands, requester i at [16*i +: 16]
//           req_apx               per-requester mode bit
//           rsp_valid/rsp_ready   result handshake
//           rsp_id/rsp_data/rsp_apx  result tag, product and mode
//           busy                  any pipeline stage occupied
//           issue_cnt             accepted-request counter (wraps)
// Revision: 1.0 - initial release
// ============================================================================
module mul16u_share_arbiter
  import mul16u_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = 2,
  parameter int IDW  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [MUL_W*NREQ-1:0] req_a,
  input  logic [MUL_W*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]       req_apx,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [PROD_W-1:0]     rsp_data,
  output logic                  rsp_apx,
  output logic                  busy,
  output logic [15:0]           issue_cnt
);

  logic              stall;
  logic              found;
  logic              hs;
  logic [IDW-1:0]    gnt;
  logic [IDW-1:0]    ptr;
  issue_t            issue;
  logic [PROD_W-1:0] prod_new;
  logic              unused_issue_id;

  logic              pipe_v    [LAT];
  logic [IDW-1:0]    pipe_id   [LAT];
  logic [PROD_W-1:0] pipe_data [LAT];
  logic              pipe_apx  [LAT];

  assign stall = rsp_valid & ~rsp_ready;

  // Round-robin search starting at ptr, wrapping modulo NREQ.
  always_comb begin
    int idx;
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx[IDW-1:0]]) begin
        found = 1'b1;
        gnt   = idx[IDW-1:0];
      end
    end
  end

  // Ready is held low during reset so every output reads zero while rst_n is low.
  always_comb begin
    req_ready = '0;
    if (found && !stall && rst_n) req_ready[gnt] = 1'b1;
  end

  assign hs = |req_ready;

  assign issue.id  = ID_W_MAX'(gnt);
  assign issue.a   = req_a[MUL_W*gnt +: MUL_W];
  assign issue.b   = req_b[MUL_W*gnt +: MUL_W];
  assign issue.apx = req_apx[gnt];

  // Tag bits above IDW are always zero for this NREQ.
  assign unused_issue_id = ^issue.id;

  mul16u_core_sel u_core (
    .a    (issue.a),
    .b    (issue.b),
    .apx  (issue.apx),
    .prod (prod_new)
  );

  // Whole pipeline, pointer and counter freeze together on a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < LAT; s++) begin
        pipe_v[s]    <= 1'b0;
        pipe_id[s]   <= '0;
        pipe_data[s] <= '0;
        pipe_apx[s]  <= 1'b0;
      end
      ptr       <= '0;
      issue_cnt <= '0;
    end else if (!stall) begin
      pipe_v[0] <= hs;
      if (hs) begin
        pipe_id[0]   <= issue.id[IDW-1:0];
        pipe_data[0] <= prod_new;
        pipe_apx[0]  <= issue.apx;
        ptr          <= (gnt == IDW'(NREQ-1)) ? '0 : gnt + 1'b1;
        issue_cnt    <= issue_cnt + 16'd1;
      end
      for (int s = 1; s < LAT; s++) begin
        pipe_v[s]    <= pipe_v[s-1];
        pipe_id[s]   <= pipe_id[s-1];
        pipe_data[s] <= pipe_data[s-1];
        pipe_apx[s]  <= pipe_apx[s-1];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int s = 0; s < LAT; s++) busy = busy | pipe_v[s];
  end

  assign rsp_valid = pipe_v[LAT-1];
  assign rsp_id    = pipe_id[LAT-1];
  assign rsp_data  = pipe_data[LAT-1];
  assign rsp_apx   = pipe_apx[LAT-1];

endmodule : mul16u_share_arbiter
`default_nettype wire

// File: tb/tb_mul16u_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mul16u_share_arbiter
// Purpose : Self-checking bench for mul16u_share_arbiter: directed vector
//           table, round-robin order, backpressure, pointer, counter wrap and
//           asynchronous reset, with a response scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mul16u_share_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 2;
  localparam int IDW  = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [16*NREQ-1:0]    req_a;
  logic [16*NREQ-1:0]    req_b;
  logic [NREQ-1:0]       req_apx;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [31:0]           rsp_data;
  logic                  rsp_apx;
  logic                  busy;
  logic [15:0]           issue_cnt;

  always #5 clk = ~clk;

  mul16u_share_arbiter #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_apx   (req_apx),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_apx   (rsp_apx),
    .busy      (busy),
    .issue_cnt (issue_cnt)
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    data;
    logic           apx;
  } exp_t;

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic        apx;
    logic [31:0] exp;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[8];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input logic apx);
    logic [7:0] hi;
    hi = {4'b0, a[15:12]} * {4'b0, b[15:12]};
    if (apx) return {hi, 24'h0};
    return {16'h0, a} * {16'h0, b};
  endfunction

  // Scoreboard: pop on every accepted response, push on every accepted request.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          vec_cnt++;
          err_cnt++;
          $display("FAIL sb_underflow: got rsp id=%0d data=%h expected no response", rsp_id, rsp_data);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_data", rsp_data, mon_e.data);
          chk("sb_id", 32'(rsp_id), 32'(mon_e.id));
          chk("sb_apx", 32'(rsp_apx), 32'(mon_e.apx));
        end
      end
      for (int g = 0; g < NREQ; g++) begin
        if (req_valid[g] && req_ready[g]) begin
          mon_e.id   = g[IDW-1:0];
          mon_e.data = model(req_a[16*g +: 16], req_b[16*g +: 16], req_apx[g]);
          mon_e.apx  = req_apx[g];
          sb.push_back(mon_e);
        end
      end
    end
  end

  task automatic do_reset();
    req_valid = '0;
    rst_n     = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_sb_empty"}, sb.size(), 0);
    chk({name, "_idle"}, 32'(busy), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string name);
    chk({name, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({name, "_rsp_id"}, 32'(rsp_id), 0);
    chk({name, "_rsp_data"}, rsp_data, 0);
    chk({name, "_rsp_apx"}, 32'(rsp_apx), 0);
    chk({name, "_busy"}, 32'(busy), 0);
    chk({name, "_issue_cnt"}, 32'(issue_cnt), 0);
    chk({name, "_req_ready"}, 32'(req_ready), 0);
  endtask

  task automatic run_vec(input vec_t v);
    logic got;
    int   lat;
    req_a[16*v.id +: 16] = v.a;
    req_b[16*v.id +: 16] = v.b;
    req_apx[v.id]        = v.apx;
    req_valid            = '0;
    req_valid[v.id]      = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready[v.id]) got = 1'b1;
    end
    chk("vec_grant", 32'(got), 1);
    @(posedge clk); #1;
    req_valid = '0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    chk("vec_latency", lat, LAT);
    chk("vec_data", rsp_data, v.exp);
    chk("vec_id", 32'(rsp_id), 32'(v.id));
    chk("vec_apx", 32'(rsp_apx), 32'(v.apx));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] cap_data;
    logic [IDW-1:0] cap_id;
    logic cap_apx;
    logic [15:0] cap_cnt;
    int n;

    vecs[0] = '{id: 0, a: 16'hFFFF, b: 16'hFFFF, apx: 1'b0, exp: 32'hFFFE0001};
    vecs[1] = '{id: 0, a: 16'hFFFF, b: 16'hFFFF, apx: 1'b1, exp: 32'hE1000000};
    vecs[2] = '{id: 1, a: 16'h0FFF, b: 16'hFFFF, apx: 1'b1, exp: 32'h00000000};
    vecs[3] = '{id: 2, a: 16'h1234, b: 16'h5678, apx: 1'b0, exp: 32'h06260060};
    vecs[4] = '{id: 3, a: 16'h1234, b: 16'h5678, apx: 1'b1, exp: 32'h05000000};
    vecs[5] = '{id: 1, a: 16'h8000, b: 16'h0002, apx: 1'b0, exp: 32'h00010000};
    vecs[6] = '{id: 3, a: 16'hF000, b: 16'h1000, apx: 1'b1, exp: 32'h0F000000};
    vecs[7] = '{id: 2, a: 16'h0000, b: 16'hFFFF, apx: 1'b0, exp: 32'h00000000};

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_apx   = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, one request at a time.
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);
    drain("vec");

    // Round robin with all requesters held valid.
    do_reset();
    for (int g = 0; g < NREQ; g++) begin
      req_a[16*g +: 16] = 16'($urandom);
      req_b[16*g +: 16] = 16'($urandom);
      req_apx[g]        = 1'($urandom);
    end
    req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rr_grant", 32'(req_ready), 32'(1 << (i % NREQ)));
      @(posedge clk); #1;
      req_a[16*(i % NREQ) +: 16] = 16'($urandom);
      req_b[16*(i % NREQ) +: 16] = 16'($urandom);
      req_apx[i % NREQ]          = 1'($urandom);
    end
    req_valid = '0;
    chk("rr_issue_cnt", 32'(issue_cnt), 8);
    drain("rr");

    // Backpressure with a full pipe.
    rsp_ready = 1'b0;
    req_valid = '1;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_fill", 32'(rsp_valid), 1);
    repeat (3) @(negedge clk);
    cap_data = rsp_data;
    cap_id   = rsp_id;
    cap_apx  = rsp_apx;
    cap_cnt  = issue_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_req_ready", 32'(req_ready), 0);
      chk("bp_rsp_valid", 32'(rsp_valid), 1);
      chk("bp_rsp_data", rsp_data, cap_data);
      chk("bp_rsp_id", 32'(rsp_id), 32'(cap_id));
      chk("bp_rsp_apx", 32'(rsp_apx), 32'(cap_apx));
      chk("bp_issue_cnt", 32'(issue_cnt), 32'(cap_cnt));
      chk("bp_busy", 32'(busy), 1);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    req_valid = '0;
    drain("bp");

    // Pointer: grant to 3 wraps ptr to 0, then 2 alone wins, ptr becomes 3.
    do_reset();
    req_valid = 4'b1000;
    @(negedge clk);
    chk("ptr_g3", 32'(req_ready), 32'h8);
    @(posedge clk); #1;
    req_valid = 4'b0100;
    @(negedge clk);
    chk("ptr_g2", 32'(req_ready), 32'h4);
    @(posedge clk); #1;
    req_valid = 4'b1111;
    @(negedge clk);
    chk("ptr_after2", 32'(req_ready), 32'h8);
    @(posedge clk); #1;
    req_valid = '0;
    drain("ptr");

    // Issue counter wrap.
    do_reset();
    req_a[15:0] = 16'h00FF;
    req_b[15:0] = 16'hF00F;
    req_apx[0]  = 1'b0;
    req_valid   = 4'b0001;
    repeat (65535) @(posedge clk);
    #1;
    chk("wrap_ffff", 32'(issue_cnt), 32'hFFFF);
    @(posedge clk); #1;
    req_valid = '0;
    chk("wrap_zero", 32'(issue_cnt), 0);
    drain("wrap");

    // Asynchronous reset with results in flight.
    req_valid = '1;
    repeat (4) @(posedge clk);
    #3;
    chk("ar_busy_before", 32'(busy), 1);
    rst_n     = 1'b0;
    sb.delete();
    req_valid = '0;
    #1;
    check_zero("areset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2*LAT + 4; i++) begin
      @(negedge clk);
      chk("ar_no_stale_rsp", 32'(rsp_valid), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule : tb_mul16u_share_arbiter
`default_nettype wire
